// File: rtl/wb_dbg_pkg.sv
// Shared types and byte codes for the UART-to-Wishbone debug master.
package wb_dbg_pkg;

    // Bridge control states.
    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        REQ  = 3'd3,
        WAIT = 3'd4,
        RESP = 3'd5
    } state_e;

    // Command opcodes.
    localparam logic [7:0] OP_WR = 8'h57;
    localparam logic [7:0] OP_RD = 8'h52;

    // Response status bytes.
    localparam logic [7:0] ST_OK  = 8'h4B;
    localparam logic [7:0] ST_ERR = 8'h45;
    localparam logic [7:0] ST_TMO = 8'h54;
    localparam logic [7:0] ST_BAD = 8'h3F;

    // True for a byte that starts a valid command frame.
    function automatic logic is_opcode(input logic [7:0] b);
        return (b == OP_WR) || (b == OP_RD);
    endfunction

endpackage

// File: rtl/wb_uart_dbg_master.sv
// Byte-stream command decoder driving a single-outstanding Wishbone
// pipelined master; answers each frame with a status byte (+ read data).
module wb_uart_dbg_master
    import wb_dbg_pkg::*;
#(
    parameter int unsigned ACK_TIMEOUT = 1024,
    parameter int unsigned RX_TIMEOUT  = 100000,
    parameter int unsigned CNT_W       = 20
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_ni,
    input  logic [7:0]  rx_dat_i,
    input  logic        rx_vld_i,
    output logic        rx_rdy_o,
    output logic [7:0]  tx_dat_o,
    output logic        tx_vld_o,
    input  logic        tx_rdy_i,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i,
    output logic        busy_o
);

    // Last counter value before an abort; the shared counter serves both
    // the bus-response timeout and the inter-byte timeout.
    localparam logic [CNT_W-1:0] ACK_LAST = CNT_W'(ACK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] RX_LAST  = CNT_W'(RX_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic             we_q, we_d;
    logic [31:0]      adr_q, adr_d;
    logic [31:0]      wdat_q, wdat_d;
    logic [31:0]      rdat_q, rdat_d;
    logic [7:0]       status_q, status_d;
    logic [1:0]       idx_q, idx_d;
    logic [2:0]       txi_q, txi_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             out_en_q;
    logic             rx_fire;
    logic             tx_fire;
    logic [7:0]       tx_byte;

    // rx_rdy_o is qualified by out_en_q so it reads 0 while reset is held,
    // even though the state register already sits in IDLE.
    assign rx_rdy_o  = out_en_q &&
                       ((state_q == IDLE) || (state_q == ADDR) || (state_q == DATA));
    assign rx_fire   = rx_vld_i && rx_rdy_o;
    assign tx_vld_o  = (state_q == RESP);
    assign tx_fire   = tx_vld_o && tx_rdy_i;
    assign tx_dat_o  = tx_byte;
    assign wbm_cyc_o = (state_q == REQ) || (state_q == WAIT);
    assign wbm_stb_o = (state_q == REQ);
    assign wbm_we_o  = wbm_cyc_o && we_q;
    assign wbm_sel_o = wbm_cyc_o ? 4'hF : 4'h0;
    assign wbm_adr_o = adr_q;
    assign wbm_dat_o = wdat_q;
    assign busy_o    = (state_q != IDLE);

    // Response byte select: status first, then read data MSB first.
    always_comb begin
        case (txi_q)
            3'd1:    tx_byte = rdat_q[31:24];
            3'd2:    tx_byte = rdat_q[23:16];
            3'd3:    tx_byte = rdat_q[15:8];
            3'd4:    tx_byte = rdat_q[7:0];
            default: tx_byte = status_q;
        endcase
    end

    // Frame decode, bus request and response sequencing.
    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        adr_d    = adr_q;
        wdat_d   = wdat_q;
        rdat_d   = rdat_q;
        status_d = status_q;
        idx_d    = idx_q;
        txi_d    = txi_q;
        cnt_d    = cnt_q;
        case (state_q)
            IDLE: begin
                if (rx_fire) begin
                    if (is_opcode(rx_dat_i)) begin
                        we_d    = (rx_dat_i == OP_WR);
                        idx_d   = 2'd0;
                        cnt_d   = '0;
                        state_d = ADDR;
                    end else begin
                        status_d = ST_BAD;
                        txi_d    = 3'd0;
                        state_d  = RESP;
                    end
                end
            end
            ADDR: begin
                if (rx_fire) begin
                    adr_d = {adr_q[23:0], rx_dat_i};
                    idx_d = idx_q + 2'd1;
                    cnt_d = '0;
                    if (idx_q == 2'd3) begin
                        state_d = we_q ? DATA : REQ;
                    end
                end else if (cnt_q == RX_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DATA: begin
                if (rx_fire) begin
                    wdat_d = {wdat_q[23:0], rx_dat_i};
                    idx_d  = idx_q + 2'd1;
                    cnt_d  = '0;
                    if (idx_q == 2'd3) begin
                        state_d = REQ;
                    end
                end else if (cnt_q == RX_LAST) begin
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            REQ: begin
                // A response in the acceptance cycle itself skips WAIT.
                if (!wbm_stall_i) begin
                    cnt_d = '0;
                    txi_d = 3'd0;
                    if (wbm_err_i) begin
                        status_d = ST_ERR;
                        state_d  = RESP;
                    end else if (wbm_ack_i) begin
                        status_d = ST_OK;
                        if (!we_q) begin
                            rdat_d = wbm_dat_i;
                        end
                        state_d = RESP;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                txi_d = 3'd0;
                if (wbm_err_i) begin
                    status_d = ST_ERR;
                    state_d  = RESP;
                end else if (wbm_ack_i) begin
                    status_d = ST_OK;
                    if (!we_q) begin
                        rdat_d = wbm_dat_i;
                    end
                    state_d = RESP;
                end else if (cnt_q == ACK_LAST) begin
                    status_d = ST_TMO;
                    state_d  = RESP;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            RESP: begin
                if (tx_fire) begin
                    if (!we_q && (status_q == ST_OK) && (txi_q != 3'd4)) begin
                        txi_d = txi_q + 3'd1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers; reset drops any bus cycle at once.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            state_q  <= IDLE;
            we_q     <= 1'b0;
            adr_q    <= '0;
            wdat_q   <= '0;
            rdat_q   <= '0;
            status_q <= '0;
            idx_q    <= '0;
            txi_q    <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            adr_q    <= adr_d;
            wdat_q   <= wdat_d;
            rdat_q   <= rdat_d;
            status_q <= status_d;
            idx_q    <= idx_d;
            txi_q    <= txi_d;
            cnt_q    <= cnt_d;
        end
    end

    // Enables byte acceptance from the first clock edge after reset release.
    always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
        if (!wb_rst_ni) begin
            out_en_q <= 1'b0;
        end else begin
            out_en_q <= 1'b1;
        end
    end

endmodule

// File: tb/tb_wb_uart_dbg_master.sv
// Bench for wb_uart_dbg_master: directed vector table, hand-written corner
// sequences and randomized frames checked against a frame-level model.
`timescale 1ns/1ps
module tb_wb_uart_dbg_master;

    localparam int ACK_TO = 16;
    localparam int RX_TO  = 64;
    localparam int CW     = 8;

    localparam int M_ACK  = 0;
    localparam int M_ERR  = 1;
    localparam int M_IMM  = 2;
    localparam int M_NONE = 3;
    localparam int M_BOTH = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  rx_dat = 8'h00;
    logic        rx_vld = 1'b0;
    logic        rx_rdy;
    logic [7:0]  tx_dat;
    logic        tx_vld;
    logic        tx_rdy = 1'b0;
    logic        cyc, stb, we;
    logic [31:0] adr, dat_o;
    logic [3:0]  sel;
    logic [31:0] dat_i = 32'h0;
    logic        ack = 1'b0, err = 1'b0, stall = 1'b0;
    logic        busy;

    always #5 clk = ~clk;

    wb_uart_dbg_master #(
        .ACK_TIMEOUT(ACK_TO),
        .RX_TIMEOUT (RX_TO),
        .CNT_W      (CW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_ni  (rst_n),
        .rx_dat_i   (rx_dat),
        .rx_vld_i   (rx_vld),
        .rx_rdy_o   (rx_rdy),
        .tx_dat_o   (tx_dat),
        .tx_vld_o   (tx_vld),
        .tx_rdy_i   (tx_rdy),
        .wbm_cyc_o  (cyc),
        .wbm_stb_o  (stb),
        .wbm_we_o   (we),
        .wbm_adr_o  (adr),
        .wbm_dat_o  (dat_o),
        .wbm_sel_o  (sel),
        .wbm_dat_i  (dat_i),
        .wbm_ack_i  (ack),
        .wbm_err_i  (err),
        .wbm_stall_i(stall),
        .busy_o     (busy)
    );

    int checks = 0;
    int errors = 0;
    int txn_no = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- slave model ----------------
    typedef struct {
        logic [31:0] adr;
        logic [31:0] dat;
        logic        we;
        logic [3:0]  sel;
        int          stbc;
        bit          moved;
    } bus_t;

    bus_t        bus_q[$];
    logic [31:0] slv_mem[logic [31:0]];
    int          slv_mode = M_ACK;
    int          stall_cfg = 0;
    bit          pending = 0;
    int          stall_cnt = 0, stb_cycles = 0, cyc_cnt = 0, last_cyc_len = 0;
    logic [31:0] first_adr, acc_adr;
    bit          adr_moved = 0;

    function automatic logic [31:0] dflt(input logic [31:0] a);
        return a ^ 32'hA5A5_5A5A;
    endfunction

    function automatic logic [31:0] slv_rd(input logic [31:0] a);
        return slv_mem.exists(a) ? slv_mem[a] : dflt(a);
    endfunction

    // Slave responses are decided on the falling edge for the next rising edge.
    initial begin
        forever begin
            @(negedge clk);
            ack = 1'b0; err = 1'b0; stall = 1'b0;
            if (!rst_n) begin
                pending = 0; stall_cnt = 0; stb_cycles = 0; cyc_cnt = 0; adr_moved = 0;
            end else begin
                if (pending) begin
                    pending = 0;
                    if (slv_mode == M_ACK) begin ack = 1'b1; dat_i = slv_rd(acc_adr); end
                    else if (slv_mode == M_ERR) err = 1'b1;
                    else if (slv_mode == M_BOTH) begin ack = 1'b1; err = 1'b1; end
                end
                if (cyc) cyc_cnt++;
                else if (cyc_cnt > 0) begin last_cyc_len = cyc_cnt; cyc_cnt = 0; end
                if (cyc && stb) begin
                    stb_cycles++;
                    if (stb_cycles == 1) first_adr = adr;
                    else if (adr !== first_adr) adr_moved = 1;
                    if (stall_cnt < stall_cfg) begin
                        stall = 1'b1; stall_cnt++;
                    end else begin
                        bus_q.push_back('{adr, dat_o, we, sel, stb_cycles, adr_moved});
                        acc_adr = adr;
                        if (we && (slv_mode == M_ACK || slv_mode == M_IMM)) slv_mem[adr] = dat_o;
                        if (slv_mode == M_IMM) begin ack = 1'b1; dat_i = slv_rd(adr); end
                        else pending = 1;
                    end
                end
                if (!cyc) begin stall_cnt = 0; stb_cycles = 0; adr_moved = 0; end
            end
        end
    end

    // ---------------- response collector ----------------
    logic [7:0] resp_q[$];
    bit         tx_manual = 0, tx_rand = 0, tx_wait = 0, tx_unstable = 0;
    logic [7:0] tx_prev = 8'h00;

    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && tx_wait && (!tx_vld || tx_dat !== tx_prev)) tx_unstable = 1;
            if (!tx_manual) tx_rdy = tx_rand ? 1'($urandom_range(0, 1)) : 1'b1;
            if (rst_n && tx_vld && tx_rdy) resp_q.push_back(tx_dat);
            tx_wait = rst_n && tx_vld && !tx_rdy;
            tx_prev = tx_dat;
        end
    end

    // ---------------- reference model ----------------
    logic [31:0] model_mem[logic [31:0]];
    logic [7:0]  exp_q[$];

    function automatic bit valid_op(input logic [7:0] o);
        return (o == 8'h57) || (o == 8'h52);
    endfunction

    task automatic model_exec(input logic [7:0] opc, input logic [31:0] a,
                              input logic [31:0] d, input int mode);
        logic [31:0] v;
        exp_q.delete();
        if (!valid_op(opc)) exp_q.push_back(8'h3F);
        else if (mode == M_ERR || mode == M_BOTH) exp_q.push_back(8'h45);
        else if (mode == M_NONE) exp_q.push_back(8'h54);
        else begin
            exp_q.push_back(8'h4B);
            if (opc == 8'h57) model_mem[a] = d;
            else begin
                v = model_mem.exists(a) ? model_mem[a] : dflt(a);
                exp_q.push_back(v[31:24]); exp_q.push_back(v[23:16]);
                exp_q.push_back(v[15:8]);  exp_q.push_back(v[7:0]);
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        rx_dat = b; rx_vld = 1'b1;
        while (!rx_rdy && n < 3000) begin @(negedge clk); n++; end
        if (n >= 3000) begin
            check("rx_accept_wait", 64'd0, 64'd1);
            rx_vld = 1'b0;
            return;
        end
        @(posedge clk); #1;
        rx_vld = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d);
        send_byte(opc);
        if (valid_op(opc)) begin
            for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
            if (opc == 8'h57) for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
            check("cyc_latency", 64'(cyc), 64'd1);
        end
    endtask

    task automatic wait_done();
        int n = 0;
        do begin @(negedge clk); n++; end while ((busy || resp_q.size() == 0) && n < 4000);
        if (n >= 4000) check("frame_done_wait", 64'd0, 64'd1);
    endtask

    task automatic check_bus(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d,
                             input int mode, input int stl, input int nb);
        bus_t b;
        int   exp_len;
        if (!valid_op(opc)) begin
            check("bus_none", 64'(bus_q.size()), 64'(nb));
            return;
        end
        check("bus_count", 64'(bus_q.size()), 64'(nb + 1));
        if (bus_q.size() == 0) return;
        b = bus_q[$];
        check("bus_adr", 64'(b.adr), 64'(a));
        check("bus_we", 64'(b.we), 64'(opc == 8'h57));
        check("bus_sel", 64'(b.sel), 64'hF);
        if (opc == 8'h57) check("bus_dat", 64'(b.dat), 64'(d));
        check("bus_stb_cycles", 64'(b.stbc), 64'(stl + 1));
        check("bus_adr_stable", 64'(b.moved), 64'd0);
        if (mode == M_IMM) exp_len = stl + 1;
        else if (mode == M_NONE) exp_len = stl + 1 + ACK_TO;
        else exp_len = stl + 2;
        check("bus_cyc_len", 64'(last_cyc_len), 64'(exp_len));
    endtask

    task automatic do_txn(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] d,
                          input int mode, input int stl);
        int nb;
        slv_mode = mode; stall_cfg = stl; nb = bus_q.size();
        model_exec(opc, a, d, mode);
        resp_q.delete();
        send_frame(opc, a, d);
        wait_done();
        check("resp_len", 64'(resp_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
            check("resp_byte", 64'(resp_q[i]), 64'(exp_q[i]));
        check_bus(opc, a, d, mode, stl, nb);
        txn_no++;
        $display("txn %0d opc=%02h adr=%08h dat=%08h mode=%0d stall=%0d resp_bytes=%0d",
                 txn_no, opc, a, d, mode, stl, resp_q.size());
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic [7:0]  opc;
        logic [31:0] adr;
        logic [31:0] dat;
        int          mode;
        int          stl;
        logic [7:0]  exp_st;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vt[11];

    initial begin
        #500000;
        $display("FAIL watchdog expired actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int          cnt;
        int          nb;
        int          r;
        logic [7:0]  opc;
        logic [31:0] a, d;

        vt[0]  = '{8'h57, 32'h0100_0010, 32'hDEAD_BEEF, M_ACK,  0, 8'h4B, 32'h0};
        vt[1]  = '{8'h52, 32'h0100_0010, 32'h0,         M_ACK,  3, 8'h4B, 32'hDEAD_BEEF};
        vt[2]  = '{8'h57, 32'h0000_0020, 32'h1122_3344, M_ERR,  0, 8'h45, 32'h0};
        vt[3]  = '{8'h52, 32'h0000_0020, 32'h0,         M_ACK,  1, 8'h4B, 32'hA5A5_5A7A};
        vt[4]  = '{8'h57, 32'h0000_0030, 32'hCAFE_F00D, M_IMM,  0, 8'h4B, 32'h0};
        vt[5]  = '{8'h52, 32'h0000_0030, 32'h0,         M_IMM,  2, 8'h4B, 32'hCAFE_F00D};
        vt[6]  = '{8'h52, 32'h0000_0040, 32'h0,         M_NONE, 0, 8'h54, 32'h0};
        vt[7]  = '{8'h00, 32'h0,         32'h0,         M_ACK,  0, 8'h3F, 32'h0};
        vt[8]  = '{8'h57, 32'h0000_0030, 32'h5555_5555, M_BOTH, 1, 8'h45, 32'h0};
        vt[9]  = '{8'h52, 32'h0000_0030, 32'h0,         M_ACK,  0, 8'h4B, 32'hCAFE_F00D};
        vt[10] = '{8'hA5, 32'h0,         32'h0,         M_ACK,  0, 8'h3F, 32'h0};

        // Reset state.
        repeat (3) @(negedge clk);
        check("rst_rx_rdy", 64'(rx_rdy), 64'd0);
        check("rst_tx_vld", 64'(tx_vld), 64'd0);
        check("rst_tx_dat", 64'(tx_dat), 64'd0);
        check("rst_cyc", 64'(cyc), 64'd0);
        check("rst_stb", 64'(stb), 64'd0);
        check("rst_we", 64'(we), 64'd0);
        check("rst_adr", 64'(adr), 64'd0);
        check("rst_dat", 64'(dat_o), 64'd0);
        check("rst_sel", 64'(sel), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        rst_n = 1'b1;

        // Table-driven directed frames.
        foreach (vt[i]) begin
            do_txn(vt[i].opc, vt[i].adr, vt[i].dat, vt[i].mode, vt[i].stl);
            check("vec_status", 64'(resp_q.size() > 0 ? resp_q[0] : 8'h00), 64'(vt[i].exp_st));
            if (vt[i].opc == 8'h52 && vt[i].exp_st == 8'h4B) begin
                if (resp_q.size() == 5)
                    check("vec_rdata", 64'({resp_q[1], resp_q[2], resp_q[3], resp_q[4]}),
                          64'(vt[i].exp_rd));
                else
                    check("vec_rdata_len", 64'(resp_q.size()), 64'd5);
            end
        end

        // Partial frame then silence: dropped without response.
        slv_mode = M_ACK; stall_cfg = 0;
        resp_q.delete(); nb = bus_q.size();
        send_byte(8'h52);
        send_byte(8'h01);
        cnt = 0;
        forever begin
            @(negedge clk);
            if (!busy || cnt >= RX_TO * 4) break;
            cnt++;
        end
        check("partial_idle_cycles", 64'(cnt), 64'(RX_TO));
        check("partial_busy", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        check("partial_no_resp", 64'(resp_q.size()), 64'd0);
        check("partial_no_bus", 64'(bus_q.size()), 64'(nb));
        do_txn(8'h52, 32'h0100_0010, 32'h0, M_ACK, 0);

        // Response back-pressure: DE held, no rx acceptance.
        tx_manual = 1; tx_rdy = 1'b0;
        slv_mode = M_ACK; stall_cfg = 0;
        model_exec(8'h52, 32'h0100_0010, 32'h0, M_ACK);
        resp_q.delete();
        send_frame(8'h52, 32'h0100_0010, 32'h0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!tx_vld && cnt < 200);
        check("bp_tx_vld_seen", 64'(tx_vld), 64'd1);
        @(posedge clk); #1 tx_rdy = 1'b1;
        @(posedge clk); #1 tx_rdy = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("bp_hold_dat", 64'(tx_dat), 64'hDE);
            check("bp_hold_vld", 64'(tx_vld), 64'd1);
            check("bp_rx_rdy", 64'(rx_rdy), 64'd0);
        end
        @(posedge clk); #1 tx_manual = 0;
        wait_done();
        check("bp_resp_len", 64'(resp_q.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size() && i < resp_q.size(); i++)
            check("bp_resp_byte", 64'(resp_q[i]), 64'(exp_q[i]));

        // Asynchronous reset in WAIT.
        slv_mode = M_NONE; stall_cfg = 0;
        send_frame(8'h52, 32'h0000_0040, 32'h0);
        cnt = 0;
        do begin @(negedge clk); cnt++; end while (!(cyc && !stb) && cnt < 100);
        #2 rst_n = 1'b0;
        #1;
        check("arst_cyc", 64'(cyc), 64'd0);
        check("arst_stb", 64'(stb), 64'd0);
        check("arst_tx_vld", 64'(tx_vld), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        resp_q.delete();
        do_txn(8'h57, 32'h0000_0050, 32'h0BAD_F00D, M_ACK, 1);
        do_txn(8'h52, 32'h0000_0050, 32'h0, M_ACK, 0);

        // Randomized frames with random response back-pressure.
        tx_rand = 1;
        for (int t = 0; t < 30; t++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + 32'(4 * $urandom_range(0, 3));
            d = $urandom;
            opc = ($urandom_range(0, 1) == 1) ? 8'h57 : 8'h52;
            if (r == 9) begin
                opc = 8'($urandom_range(0, 255));
                if (valid_op(opc)) opc = 8'h00;
            end
            do_txn(opc, a, d,
                   (r <= 4 || r == 9) ? M_ACK : (r == 5) ? M_ERR : (r == 6) ? M_IMM :
                   (r == 7) ? M_BOTH : M_NONE,
                   $urandom_range(0, 3));
        end
        tx_rand = 0;

        check("tx_stable_under_backpressure", 64'(tx_unstable), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wb_uart_dbg_master.md
Name: wb_uart_dbg_master

Overview:
- Byte-stream to Wishbone pipelined master bridge. It is the initiator side of the SoC slave bus.
- Decodes read/write command frames from a UART byte source and issues single Wishbone transactions.
- Returns status and read data as response bytes.
- Sits as a second master port on wbxbar (NM=2) beside picorv32_wb, for bench/host debug access.

Parameters:
- ACK_TIMEOUT, 1024: cycles to wait for ack/err after stb is accepted; abort when reached.
- RX_TIMEOUT, 100000: idle cycles allowed between bytes of a partial frame; abort when reached.
- CNT_W, 20: width of the shared timeout counter; must satisfy 2**CNT_W > max(ACK_TIMEOUT, RX_TIMEOUT).

Ports:
- wb_clk_i  in  1  single clock.
- wb_rst_ni  in  1  reset, asynchronous assert, active-low.
- rx_dat_i  in  8  command byte.
- rx_vld_i  in  1  command byte valid.
- rx_rdy_o  out  1  bridge accepts byte.
- tx_dat_o  out  8  response byte.
- tx_vld_o  out  1  response byte valid.
- tx_rdy_i  in  1  sink accepts response byte.
- wbm_cyc_o  out  1  bus cycle.
- wbm_stb_o  out  1  strobe.
- wbm_we_o  out  1  write enable.
- wbm_adr_o  out  32  byte address.
- wbm_dat_o  out  32  write data.
- wbm_sel_o  out  4  byte select.
- wbm_dat_i  in  32  read data.
- wbm_ack_i  in  1  ack.
- wbm_err_i  in  1  error.
- wbm_stall_i  in  1  stall.
- busy_o  out  1  high in any state except IDLE.

Behaviour:
- Reset (wb_rst_ni low, asynchronous):
  - All outputs 0.
  - State IDLE, counters 0.
  - Any in-flight bus cycle drops cyc immediately. The slave may be left with a dangling ack; the bridge ignores it.
- Byte handshake:
  - A byte transfers on the rising edge where vld and rdy are both 1.
  - rx_rdy_o is 1 only in IDLE, ADDR and DATA.
  - tx_dat_o and tx_vld_o hold stable until tx_rdy_i is 1.
- Frame format (multi-byte fields are big-endian):
  - Write: 0x57, A3..A0, D3..D0.
  - Read: 0x52, A3..A0.
- States:
  - IDLE: on opcode 0x57 or 0x52, latch we and go to ADDR with byte index 0. On any other byte, go to RESP with status 0x3F.
  - ADDR: shift 4 bytes into the address register. After byte 3, go to DATA if write, otherwise REQ.
  - DATA: shift 4 bytes into the data register. After byte 3, go to REQ.
  - REQ: cyc=1, stb=1, sel=4'hF, adr/dat/we from the registers. Hold stb while stall=1. On the first edge with stall=0, clear stb, clear the counter and go to WAIT.
  - WAIT: cyc=1, stb=0; the counter increments each cycle.
    - ack: latch wbm_dat_i if read, status 0x4B.
    - err: status 0x45.
    - counter reaches ACK_TIMEOUT-1 without ack/err: status 0x54.
    - In every case cyc drops on the next edge and the state goes to RESP.
    - If ack and err arrive in the same cycle, err wins.
    - ack or err arriving in REQ, in the same cycle stb is accepted, is honoured: skip WAIT and go directly to RESP.
  - RESP: send the status byte. If read and status is 0x4B, then send D3..D0 of the read data. Return to IDLE after the last byte handshake.
- Inter-byte timeout:
  - In ADDR/DATA the counter increments every cycle with no byte and clears on each accepted byte.
  - At RX_TIMEOUT-1, discard the partial frame, return to IDLE and send no response.
- Bus rules:
  - Latency from the last frame byte to cyc=1 is exactly one cycle.
  - cyc is never asserted outside REQ/WAIT.
  - Only one outstanding request exists.
  - wbm_dat_o is meaningful only when we=1.
- rx bytes arriving outside IDLE/ADDR/DATA are not accepted; upstream back-pressure holds them.

Decomposition:
- Package wb_dbg_pkg holds:
  - state enum (IDLE, ADDR, DATA, REQ, WAIT, RESP);
  - opcode constants OP_WR=8'h57, OP_RD=8'h52;
  - status constants ST_OK=8'h4B, ST_ERR=8'h45, ST_TMO=8'h54, ST_BAD=8'h3F.
- The block is a single module. The byte source/sink is wbuart's rx/tx FIFO side, wired in calsoc_top, not here.

Test Plan:
- Write: bytes 57 01 00 00 10 DE AD BE EF into a RAM model (stall=0, ack after 1 cycle).
  - Bus: one cycle with adr=0x01000010, dat=0xDEADBEEF, we=1, sel=F.
  - Response: single byte 4B.
- Read: read back with 52 01 00 00 10, slave returns 0xDEADBEEF.
  - Response: 4B DE AD BE EF.
  - stall=1 for 3 cycles keeps stb high for 4 cycles; adr is stable throughout.
- Error and timeout:
  - Slave asserts err on a write: response 45, cyc low the following cycle.
  - Slave never answers: cyc drops after ACK_TIMEOUT cycles, response 54.
- Bad opcode and partial frame:
  - Byte 0x00 in IDLE: response 3F.
  - Frame 52 01 then silence for RX_TIMEOUT cycles: no response, busy_o=0. A following full read frame succeeds.
- Back-pressure and reset:
  - tx_rdy_i=0 for 10 cycles during a read response: tx_dat_o holds DE; rx_rdy_o stays 0.
  - wb_rst_ni pulled low during WAIT: cyc, stb and tx_vld_o go to 0 immediately, with no clock edge needed. After release, the next frame completes normally.
